// File: rtl/lab2_proc_mem_arb_pkg.sv
// Shared types and constants for the imem/dmem -> test-memory arbiter.
// Message layouts mirror the 4-byte memory request/response formats.
package lab2_proc_mem_arb_pkg;

  localparam int REQ_NBITS  = 77;
  localparam int RESP_NBITS = 47;

  localparam logic MEM_ARB_PORT_IMEM = 1'b0;
  localparam logic MEM_ARB_PORT_DMEM = 1'b1;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/lab2_proc_mem_arb_order_fifo.sv
// 1-bit-wide order FIFO recording which port owns each in-flight request.
// Power-of-2 depth, so pointers wrap by natural overflow.
module lab2_proc_mem_arb_order_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_id,
  input  logic        pop,
  output logic        head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] ids;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = ids[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/lab2_proc_mem_arb.sv
// Round-robin 2:1 memory request arbiter with in-order response routing.
// Optional counters compiled in with LAB2_PROC_MEM_ARB_STATS_EN.
module lab2_proc_mem_arb
  import lab2_proc_mem_arb_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  mem_req_4B_t                           in0_req_msg,
  input  logic                                  in0_req_val,
  output logic                                  in0_req_rdy,
  input  mem_req_4B_t                           in1_req_msg,
  input  logic                                  in1_req_val,
  output logic                                  in1_req_rdy,
  output mem_resp_4B_t                          in0_resp_msg,
  output logic                                  in0_resp_val,
  input  logic                                  in0_resp_rdy,
  output mem_resp_4B_t                          in1_resp_msg,
  output logic                                  in1_resp_val,
  input  logic                                  in1_resp_rdy,
  output mem_req_4B_t                           mem_req_msg,
  output logic                                  mem_req_val,
  input  logic                                  mem_req_rdy,
  input  mem_resp_4B_t                          mem_resp_msg,
  input  logic                                  mem_resp_val,
  output logic                                  mem_resp_rdy,
  output logic [$clog2(p_max_outstanding):0]    num_outstanding
`ifdef LAB2_PROC_MEM_ARB_STATS_EN
  ,
  output logic [31:0]                           stats_grant0,
  output logic [31:0]                           stats_grant1,
  output logic [31:0]                           stats_conflict
`endif
);

  logic prio, gnt, any_val, full, empty, head, req_go, resp_go;

  always_comb begin
    any_val = in0_req_val | in1_req_val;
    gnt     = (in0_req_val & in1_req_val) ? prio
            : (in1_req_val ? MEM_ARB_PORT_DMEM : MEM_ARB_PORT_IMEM);

    // Blocking on full ignores a same-cycle pop: no resp->req comb path.
    mem_req_val = reset & any_val & ~full;
    mem_req_msg = (gnt == MEM_ARB_PORT_DMEM) ? in1_req_msg : in0_req_msg;
    in0_req_rdy = mem_req_val & mem_req_rdy & (gnt == MEM_ARB_PORT_IMEM);
    in1_req_rdy = mem_req_val & mem_req_rdy & (gnt == MEM_ARB_PORT_DMEM);

    in0_resp_msg = mem_resp_msg;
    in1_resp_msg = mem_resp_msg;
    in0_resp_val = reset & mem_resp_val & ~empty & (head == MEM_ARB_PORT_IMEM);
    in1_resp_val = reset & mem_resp_val & ~empty & (head == MEM_ARB_PORT_DMEM);
    mem_resp_rdy = reset & ~empty
                 & ((head == MEM_ARB_PORT_DMEM) ? in1_resp_rdy : in0_resp_rdy);

    req_go  = mem_req_val & mem_req_rdy;
    resp_go = mem_resp_val & mem_resp_rdy;
  end

  always_ff @(posedge clk) begin
    if (!reset)      prio <= MEM_ARB_PORT_IMEM;
    else if (req_go) prio <= other_port(gnt);
  end

  lab2_proc_mem_arb_order_fifo #(.DEPTH(p_max_outstanding)) u_order_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (req_go),
    .push_id (gnt),
    .pop     (resp_go),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (num_outstanding)
  );

`ifdef LAB2_PROC_MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stats_grant0   <= '0;
      stats_grant1   <= '0;
      stats_conflict <= '0;
    end else begin
      if (in0_req_val & in0_req_rdy)      stats_grant0   <= stats_grant0 + 32'd1;
      if (in1_req_val & in1_req_rdy)      stats_grant1   <= stats_grant1 + 32'd1;
      if (in0_req_val & in1_req_val & ~full) stats_conflict <= stats_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lab2_proc_mem_arb.sv
// Directed bench for lab2_proc_mem_arb: queue-based reference model checked
// every cycle, plus hand-computed literal checks along the test plan.
module tb_lab2_proc_mem_arb;
  import lab2_proc_mem_arb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  mem_req_4B_t  in0_req_msg, in1_req_msg, mem_req_msg;
  logic in0_req_val, in0_req_rdy, in1_req_val, in1_req_rdy;
  mem_resp_4B_t in0_resp_msg, in1_resp_msg, mem_resp_msg;
  logic in0_resp_val, in0_resp_rdy, in1_resp_val, in1_resp_rdy;
  logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  logic [$clog2(DEPTH):0] num_outstanding;
`ifdef LAB2_PROC_MEM_ARB_STATS_EN
  logic [31:0] stats_grant0, stats_grant1, stats_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lab2_proc_mem_arb #(.p_max_outstanding(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in0_req_msg(in0_req_msg), .in0_req_val(in0_req_val), .in0_req_rdy(in0_req_rdy),
    .in1_req_msg(in1_req_msg), .in1_req_val(in1_req_val), .in1_req_rdy(in1_req_rdy),
    .in0_resp_msg(in0_resp_msg), .in0_resp_val(in0_resp_val), .in0_resp_rdy(in0_resp_rdy),
    .in1_resp_msg(in1_resp_msg), .in1_resp_val(in1_resp_val), .in1_resp_rdy(in1_resp_rdy),
    .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .num_outstanding(num_outstanding)
`ifdef LAB2_PROC_MEM_ARB_STATS_EN
    , .stats_grant0(stats_grant0), .stats_grant1(stats_grant1), .stats_conflict(stats_conflict)
`endif
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding owners in a queue, one priority bit.
  bit model_q[$];
  bit model_prio = 1'b0;

  always @(negedge clk) begin
    bit any, full_m, empty_m, g, head_m, e_mrdy;
    any     = in0_req_val | in1_req_val;
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    g       = (in0_req_val && in1_req_val) ? model_prio : in1_req_val;
    head_m  = empty_m ? 1'b0 : model_q[0];
    chk("m_in0_resp_msg", in0_resp_msg, mem_resp_msg);
    chk("m_in1_resp_msg", in1_resp_msg, mem_resp_msg);
    if (!reset) begin
      chk("m_rst_mem_req_val", mem_req_val, 0);
      chk("m_rst_in0_req_rdy", in0_req_rdy, 0);
      chk("m_rst_in1_req_rdy", in1_req_rdy, 0);
      chk("m_rst_in0_resp_val", in0_resp_val, 0);
      chk("m_rst_in1_resp_val", in1_resp_val, 0);
      chk("m_rst_mem_resp_rdy", mem_resp_rdy, 0);
      model_q.delete();
      model_prio = 1'b0;
    end else begin
      e_mrdy = !empty_m && (head_m ? in1_resp_rdy : in0_resp_rdy);
      chk("m_num_outstanding", num_outstanding, model_q.size());
      chk("m_mem_req_val", mem_req_val, any && !full_m);
      if (any && !full_m) chk("m_mem_req_msg", mem_req_msg, g ? in1_req_msg : in0_req_msg);
      chk("m_in0_req_rdy", in0_req_rdy, any && !full_m && mem_req_rdy && g == 0);
      chk("m_in1_req_rdy", in1_req_rdy, any && !full_m && mem_req_rdy && g == 1);
      chk("m_in0_resp_val", in0_resp_val, mem_resp_val && !empty_m && head_m == 0);
      chk("m_in1_resp_val", in1_resp_val, mem_resp_val && !empty_m && head_m == 1);
      chk("m_mem_resp_rdy", mem_resp_rdy, e_mrdy);
      if (mem_resp_val && e_mrdy) void'(model_q.pop_front());
      if (any && !full_m && mem_req_rdy) begin
        model_q.push_back(g);
        model_prio = !g;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_req_4B_t rd(input logic [31:0] addr, input logic [7:0] op);
    mem_req_4B_t m;
    m = '{typ: 3'd0, opaque: op, addr: addr, len: 2'd0, data: 32'd0};
    return m;
  endfunction

  function automatic mem_resp_4B_t rsp(input logic [31:0] data);
    mem_resp_4B_t m;
    m = '{typ: 3'd0, opaque: 8'h5a, test: 2'd0, len: 2'd0, data: data};
    return m;
  endfunction

  task automatic idle();
    in0_req_val = 0; in1_req_val = 0; mem_resp_val = 0;
  endtask

  task automatic do_reset();
    nxt(); reset = 0; idle();
    nxt(); reset = 1;
  endtask

  initial begin
    reset = 0; idle();
    in0_req_msg = rd(32'h200, 8'h01); in1_req_msg = rd(32'h400, 8'h02);
    mem_resp_msg = rsp(32'h0); mem_req_rdy = 1; in0_resp_rdy = 1; in1_resp_rdy = 1;

    // Reset cycle: valid request must not be accepted.
    nxt(); in0_req_val = 1;
    @(negedge clk);
    chk("rst_mem_req_val", mem_req_val, 0);
    chk("rst_in0_req_rdy", in0_req_rdy, 0);

    // Single in0 read to 0x200.
    nxt(); reset = 1;
    @(negedge clk);
    chk("t1_mem_req_val", mem_req_val, 1);
    chk("t1_addr", mem_req_msg.addr, 32'h200);
    chk("t1_in0_req_rdy", in0_req_rdy, 1);
    chk("t1_num0", num_outstanding, 0);
    nxt(); in0_req_val = 0; mem_resp_val = 1; mem_resp_msg = rsp(32'hdeadbeef);
    @(negedge clk);
    chk("t1_num1", num_outstanding, 1);
    chk("t1_in0_resp_val", in0_resp_val, 1);
    chk("t1_in1_resp_val", in1_resp_val, 0);
    chk("t1_data", in0_resp_msg.data, 32'hdeadbeef);
    nxt(); mem_resp_val = 0;
    @(negedge clk);
    chk("t1_num_back0", num_outstanding, 0);

    // Dual valid: grants alternate starting with in0.
    do_reset();
    in0_req_val = 1; in1_req_val = 1; mem_resp_val = 1; mem_resp_msg = rsp(32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_in0_rdy", in0_req_rdy, (i % 2) == 0);
      chk("rr_in1_rdy", in1_req_rdy, (i % 2) == 1);
      nxt();
    end
    idle();

    // Four in1 requests fill the FIFO; fifth stalls.
    do_reset();
    in1_req_val = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fill_in1_rdy", in1_req_rdy, 1);
      nxt();
    end
    @(negedge clk);
    chk("full_in1_rdy", in1_req_rdy, 0);
    chk("full_num", num_outstanding, 4);
    nxt(); mem_resp_val = 1;
    @(negedge clk);
    chk("full_pop_rdy", mem_resp_rdy, 1);
    chk("full_same_cycle_rdy", in1_req_rdy, 0);
    nxt(); mem_resp_val = 0;
    @(negedge clk);
    chk("full_after_num", num_outstanding, 3);
    chk("full_after_rdy", in1_req_rdy, 1);
    nxt(); idle();

    // Interleaved in0,in1,in1 then ordered responses.
    do_reset();
    in0_req_val = 1;
    nxt(); in0_req_val = 0; in1_req_val = 1;
    nxt(); nxt(); in1_req_val = 0;
    mem_resp_val = 1; mem_resp_msg = rsp(32'h11);
    @(negedge clk);
    chk("il_num3", num_outstanding, 3);
    chk("il_r0_val0", in0_resp_val, 1);
    chk("il_r0_data", in0_resp_msg.data, 32'h11);
    nxt(); mem_resp_msg = rsp(32'h22); in1_resp_rdy = 0;
    @(negedge clk);
    chk("il_r1_val1", in1_resp_val, 1);
    chk("il_r1_val0", in0_resp_val, 0);
    chk("il_r1_hold", mem_resp_rdy, 0);
    chk("il_hold_num", num_outstanding, 2);
    nxt(); in1_resp_rdy = 1;
    @(negedge clk);
    chk("il_r1_rdy", mem_resp_rdy, 1);
    chk("il_r1_data", in1_resp_msg.data, 32'h22);
    nxt(); mem_resp_msg = rsp(32'h33);
    @(negedge clk);
    chk("il_r2_val1", in1_resp_val, 1);
    chk("il_r2_data", in1_resp_msg.data, 32'h33);
    nxt(); mem_resp_val = 0;
    @(negedge clk);
    chk("il_num0", num_outstanding, 0);

    // Reset with three outstanding in0 requests.
    in0_req_val = 1;
    nxt(); nxt(); nxt(); in0_req_val = 0;
    @(negedge clk);
    chk("mr_num3", num_outstanding, 3);
    nxt(); reset = 0; in0_req_val = 1; in1_req_val = 1; mem_resp_val = 1;
    @(negedge clk);
    chk("mr_mem_req_val", mem_req_val, 0);
    chk("mr_in0_resp_val", in0_resp_val, 0);
    chk("mr_mem_resp_rdy", mem_resp_rdy, 0);
    nxt(); reset = 1; mem_resp_val = 0;
    @(negedge clk);
    chk("mr_num0", num_outstanding, 0);
    chk("mr_prio_in0", in0_req_rdy, 1);
    chk("mr_prio_in1", in1_req_rdy, 0);
    nxt(); idle();

`ifdef LAB2_PROC_MEM_ARB_STATS_EN
    do_reset();
    in0_req_val = 1; in1_req_val = 1; mem_resp_val = 1;
    for (int i = 0; i < 9; i++) nxt();
    nxt(); idle();
    @(negedge clk);
    chk("st_grant0", stats_grant0, 5);
    chk("st_grant1", stats_grant1, 5);
    chk("st_conflict", stats_conflict, 10);
`endif

    nxt(); nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
